// File: rtl/rot_reservation_station.sv
// Reservation station for the pipelined rotate/shift unit. Holds dispatched
// rotate instructions until op1, op2 and target are all present, snoops the
// result bus for missing operands, and issues ready entries to the unit. An
// entry keeps its tag reserved until its own result is broadcast.

package rot_pkg;

    // Decoded rotate control carried alongside the operands.
    typedef struct packed {
        logic [1:0] kind;  // rotate / shift-left / shift-right / arith-shift
        logic       dir;
        logic       word;
    } rotate_decode_t;

endpackage

module rot_reservation_station
    import rot_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_OFFSET   = 0,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic                   op1_valid,
    input  logic                   op2_valid,
    input  logic                   target_valid,
    input  logic [31:0]            op1_value,
    input  logic [31:0]            op2_value,
    input  logic [31:0]            target_value,
    input  logic [RS_ID_WIDTH-1:0] op1_rs_id,
    input  logic [RS_ID_WIDTH-1:0] op2_rs_id,
    input  logic [RS_ID_WIDTH-1:0] target_rs_id,
    input  logic [4:0]             result_reg_addr_in,
    input  rotate_decode_t         control_in,

    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,

    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1,
    output logic [31:0]            op2,
    output logic [31:0]            target,
    output rotate_decode_t         control
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StFree, StWaiting, StReady, StIssued} entry_state_e;

    // Operand slot 0 = op1, 1 = op2, 2 = target.
    entry_state_e                     state_q   [DEPTH];
    entry_state_e                     state_d   [DEPTH];
    logic [2:0]                       present_q [DEPTH];
    logic [2:0]                       present_d [DEPTH];
    logic [2:0][31:0]                 val_q     [DEPTH];
    logic [2:0][31:0]                 val_d     [DEPTH];
    logic [2:0][RS_ID_WIDTH-1:0]      tag_q     [DEPTH];
    logic [2:0][RS_ID_WIDTH-1:0]      tag_d     [DEPTH];
    logic [4:0]                       rd_q      [DEPTH];
    logic [4:0]                       rd_d      [DEPTH];
    rotate_decode_t                   ctrl_q    [DEPTH];
    rotate_decode_t                   ctrl_d    [DEPTH];

    logic                             free_any;
    logic                             ready_any;
    logic [IdxW-1:0]                  alloc_idx;
    logic [IdxW-1:0]                  sel_idx;
    logic                             dispatch_fire;
    logic                             issue_fire;

    logic [2:0]                       disp_valid;
    logic [2:0][31:0]                 disp_value;
    logic [2:0][RS_ID_WIDTH-1:0]      disp_tag;

    assign disp_valid = {target_valid, op2_valid, op1_valid};
    assign disp_value = {target_value, op2_value, op1_value};
    assign disp_tag   = {target_rs_id, op2_rs_id, op1_rs_id};

    // Lowest-index FREE entry for allocation, lowest-index READY entry for issue.
    always_comb begin
        free_any  = 1'b0;
        ready_any = 1'b0;
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (state_q[i] == StFree) begin
                free_any  = 1'b1;
                alloc_idx = IdxW'(i);
            end
            if (state_q[i] == StReady) begin
                ready_any = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    assign dispatch_ready = rst & free_any;
    assign dispatch_fire  = dispatch_valid & dispatch_ready;
    assign issue_valid    = ready_any;
    assign issue_fire     = issue_valid & issue_ready;

    // Issue payload from the selected entry; forced to zero when nothing is ready.
    always_comb begin
        rs_id_out           = '0;
        result_reg_addr_out = '0;
        op1                 = '0;
        op2                 = '0;
        target              = '0;
        control             = '0;
        if (ready_any) begin
            rs_id_out           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx);
            result_reg_addr_out = rd_q[sel_idx];
            op1                 = val_q[sel_idx][0];
            op2                 = val_q[sel_idx][1];
            target              = val_q[sel_idx][2];
            control             = ctrl_q[sel_idx];
        end
    end

    // Per-entry next state: dispatch, wakeup, issue and free are exclusive per
    // entry because each acts on a different current state.
    always_comb begin
        state_d   = state_q;
        present_d = present_q;
        val_d     = val_q;
        tag_d     = tag_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            case (state_q[i])
                StFree: begin
                    if (dispatch_fire && alloc_idx == IdxW'(i)) begin
                        for (int k = 0; k < 3; k++) begin
                            tag_d[i][k] = disp_tag[k];
                            if (disp_valid[k]) begin
                                present_d[i][k] = 1'b1;
                                val_d[i][k]     = disp_value[k];
                            end else if (cdb_valid && disp_tag[k] == cdb_rs_id) begin
                                // Producer broadcasting in the dispatch cycle.
                                present_d[i][k] = 1'b1;
                                val_d[i][k]     = cdb_result;
                            end else begin
                                present_d[i][k] = 1'b0;
                                val_d[i][k]     = '0;
                            end
                        end
                        rd_d[i]    = result_reg_addr_in;
                        ctrl_d[i]  = control_in;
                        state_d[i] = (&present_d[i]) ? StReady : StWaiting;
                    end
                end
                StWaiting: begin
                    if (cdb_valid) begin
                        for (int k = 0; k < 3; k++) begin
                            if (!present_q[i][k] && tag_q[i][k] == cdb_rs_id) begin
                                present_d[i][k] = 1'b1;
                                val_d[i][k]     = cdb_result;
                            end
                        end
                        if (&present_d[i]) state_d[i] = StReady;
                    end
                end
                StReady: begin
                    if (issue_fire && sel_idx == IdxW'(i)) state_d[i] = StIssued;
                end
                StIssued: begin
                    if (cdb_valid && cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + 32'(i))) begin
                        state_d[i] = StFree;
                    end
                end
                default: state_d[i] = StFree;
            endcase
        end
    end

    // Entry storage; synchronous active-low reset discards every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i]   <= StFree;
                present_q[i] <= '0;
                val_q[i]     <= '0;
                tag_q[i]     <= '0;
                rd_q[i]      <= '0;
                ctrl_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            present_q <= present_d;
            val_q     <= val_d;
            tag_q     <= tag_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

// File: doc/rot_reservation_station.md
# rot_reservation_station

Reservation station that feeds the pipelined rotate/shift unit: accepts dispatched rotate instructions, holds them until all three operands (op1, op2, target) are available, snoops the common result bus for missing operands, and issues ready entries over the unit's valid/ready input handshake. Each entry's rs_id is the tag consumers wait on, so an entry stays allocated until its own result is broadcast.

## Interface
- RS_ID_WIDTH, 5, width of rs_id tags system-wide
- RS_OFFSET, 0, rs_id of entry 0; entry i has rs_id RS_OFFSET+i
- DEPTH, 2, number of entries (1..8); RS_OFFSET+DEPTH-1 must fit in RS_ID_WIDTH

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets)
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  a FREE entry exists
- op1_valid / op2_valid / target_valid  in  1 each  operand value present (else wait on tag)
- op1_value / op2_value / target_value  in  32 each  operand values
- op1_rs_id / op2_rs_id / target_rs_id  in  RS_ID_WIDTH each  producer tags when not valid
- result_reg_addr_in  in  5  destination GPR
- control_in  in  rotate_decode_t  decoded rotate control
- cdb_valid  in  1  result bus broadcast
- cdb_rs_id  in  RS_ID_WIDTH  tag of broadcast result
- cdb_result  in  32  broadcast value
- issue_valid  out  1  to rotate unit input_valid
- issue_ready  in  1  from rotate unit input_ready
- rs_id_out  out  RS_ID_WIDTH  issued entry's tag
- result_reg_addr_out  out  5
- op1 / op2 / target  out  32 each
- control  out  rotate_decode_t

## Operation
- Per-entry state: FREE, WAITING (≥1 operand missing), READY (all present, not issued), ISSUED (sent, awaiting own result).
- Dispatch: handshake when dispatch_valid & dispatch_ready; lowest-index FREE entry allocated. Operand marked present if its valid bit is set, or if cdb_valid and cdb_rs_id equals its tag in the same cycle (value taken from cdb_result). Entry goes to READY if all three present, else WAITING.
- Wakeup: every cycle with cdb_valid, each WAITING entry captures cdb_result into every missing operand whose tag equals cdb_rs_id; entry becomes READY when the last operand fills.
- Issue: select lowest-index READY entry; issue_valid=1 iff any READY entry; payload outputs from selected entry, all zero when issue_valid=0. issue_valid/payload are functions of registered state only, never of issue_ready. On issue_valid & issue_ready the entry goes READY→ISSUED. Payload stable while issue_valid=1 and issue_ready=0 unless a lower-index entry becomes READY (allowed; rotate unit samples only on handshake).
- Free: cdb_valid with cdb_rs_id = RS_OFFSET+i and entry i ISSUED → FREE. Matching tag on a non-ISSUED entry is ignored for freeing.
- dispatch_ready = rst & (any entry FREE), from registered state; an entry freed this cycle is allocatable next cycle.
- Simultaneous events allowed in one cycle: dispatch into entry a, wakeup of several entries, issue of entry b, free of entry c; all take effect at the same edge. A broadcast can wake operands and free an ISSUED entry in the same cycle.
- Reset: all entries FREE, operand-present bits cleared; reset mid-operation discards all entries, including ISSUED ones.

## Timing
- Reset values: dispatch_ready=0 while rst=0, 1 the cycle after rst releases; issue_valid=0; rs_id_out, result_reg_addr_out, op1, op2, target, control all 0.
- Dispatch with all operands valid at edge N → issue_valid=1 in cycle N (after edge), i.e. first issue handshake possible one cycle after dispatch.
- Wakeup broadcast at edge N → entry READY, issue_valid=1 after edge N.
- Free broadcast at edge N → dispatch_ready reflects the freed entry after edge N.
- One issue per cycle max; one dispatch per cycle max.

## Test plan
- Reset, then dispatch op1=0x80000001, op2=1, target=0, all valid, issue_ready=1 → next cycle issue_valid=1, rs_id_out=RS_OFFSET, op1=0x80000001; entry ISSUED after handshake.
- Dispatch with op2_valid=0, op2_rs_id=7; broadcast cdb_rs_id=7, cdb_result=0x1F two cycles later → issue_valid rises the cycle after broadcast with op2=0x1F.
- Dispatch with op1_rs_id=9 in the same cycle cdb_valid, cdb_rs_id=9, cdb_result=0xDEADBEEF → entry READY immediately, issued op1=0xDEADBEEF.
- Fill both entries (DEPTH=2), hold issue_ready=0 → dispatch_ready=0, issue_valid=1 with rs_id_out=RS_OFFSET stable; broadcast cdb_rs_id=RS_OFFSET before issue → entry not freed (not ISSUED).
- Issue entry 0, broadcast its tag while entry 1 waits on the same tag → same cycle: entry 0 FREE, entry 1 READY; next cycle dispatch_ready=1, issue_valid=1 with rs_id_out=RS_OFFSET+1.
- Pull rst=0 with entries WAITING/ISSUED → next cycle all outputs zero, dispatch_ready=0; after release dispatch_ready=1, later broadcasts free nothing.
